// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - request, ALU drive and result bundle between decode, alu_issue and writeback
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_out, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_ctr, out_valid, out_result, out_zero, out_illegal
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_out, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctr, out_valid, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - operand issue and result capture sequencer for the integer ALU
// Optional request/illegal counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_illegal
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [3:0]       alu_ctr_q;
    logic             illegal_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_zero_q;
    logic             out_illegal_q;
    logic             in_ready;
    logic             accept;
    logic             op_illegal;

    // Code 15 is the ALU's "return zero" control, used for illegal opcodes.
    function automatic logic [3:0] decode_op(input logic [2:0] op);
        logic [3:0] ctr;
        case (op)
            3'd0:    ctr = 4'd2;
            3'd1:    ctr = 4'd6;
            3'd2:    ctr = 4'd0;
            3'd3:    ctr = 4'd1;
            3'd4:    ctr = 4'd7;
            3'd5:    ctr = 4'd12;
            default: ctr = 4'd15;
        endcase
        return ctr;
    endfunction

    assign op_illegal = (bus.in_op == 3'd6) || (bus.in_op == 3'd7);
    assign accept     = bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = EXEC;
            end
            EXEC: state_d = DONE;
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctr_q     <= 4'd15;
            illegal_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q   <= bus.in_a;
                alu_b_q   <= bus.in_b;
                alu_ctr_q <= decode_op(bus.in_op);
                illegal_q <= op_illegal;
            end
            if (state_q == EXEC) begin
                out_result_q  <= bus.alu_out;
                out_zero_q    <= bus.alu_zero;
                out_illegal_q <= illegal_q;
                out_valid_q   <= 1'b1;
            end else if (state_q == DONE && bus.out_ready) begin
                out_valid_q   <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops_q, stat_illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q     <= '0;
            stat_illegal_q <= '0;
        end else if (accept) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            if (op_illegal) stat_illegal_q <= stat_illegal_q + 32'd1;
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_illegal = stat_illegal_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ctr     = alu_ctr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a behavioural ALU
module tb_alu_issue;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_issue_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops, stat_illegal;
    alu_issue #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_ops(stat_ops), .stat_illegal(stat_illegal)
    );
`else
    alu_issue #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: SLT unsigned, unknown control codes return zero.
    always_comb begin
        case (bus.alu_ctr)
            4'd2:    bus.alu_out = bus.alu_a + bus.alu_b;
            4'd6:    bus.alu_out = bus.alu_a - bus.alu_b;
            4'd0:    bus.alu_out = bus.alu_a & bus.alu_b;
            4'd1:    bus.alu_out = bus.alu_a | bus.alu_b;
            4'd7:    bus.alu_out = {{(WIDTH-1){1'b0}}, bus.alu_a < bus.alu_b};
            4'd12:   bus.alu_out = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_out = '0;
        endcase
        bus.alu_zero = (bus.alu_out == '0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        tests++; if (bus.alu_ctr !== 4'd15) begin fails++; $display("FAIL reset_alu_ctr got=%0d exp=15", bus.alu_ctr); end
        tests++; if (bus.out_result !== 32'd0) begin fails++; $display("FAIL reset_out_result got=%0h exp=0", bus.out_result); end
        tests++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin fails++; $display("FAIL reset_operands got=%0h/%0h exp=0/0", bus.alu_a, bus.alu_b); end
        tests++; if (bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0) begin fails++; $display("FAIL reset_flags got=%0b/%0b exp=0/0", bus.out_zero, bus.out_illegal); end
    endtask

    task automatic test_add();
        drive(1'b1, 3'd0, 32'd5, 32'd7);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tests++; if (bus.alu_ctr !== 4'd2) begin fails++; $display("FAIL add_alu_ctr got=%0d exp=2", bus.alu_ctr); end
        tests++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin fails++; $display("FAIL add_operands got=%0d/%0d exp=5/7", bus.alu_a, bus.alu_b); end
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL add_exec_handshake got valid=%0b ready=%0b exp 0/0", bus.out_valid, bus.in_ready); end
        step();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got=%0b exp=1", bus.out_valid); end
        tests++; if (bus.out_result !== 32'd12) begin fails++; $display("FAIL add_result got=%0d exp=12", bus.out_result); end
        tests++; if (bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0) begin fails++; $display("FAIL add_flags got=%0b/%0b exp=0/0", bus.out_zero, bus.out_illegal); end
        step();
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL add_to_idle got valid=%0b ready=%0b exp 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd1, 32'd9, 32'd9);
        bus.out_ready = 1'b1;
        step();
        drive(1'b1, 3'd4, 32'd3, 32'd8);
        tests++; if (bus.alu_ctr !== 4'd6) begin fails++; $display("FAIL sub_alu_ctr got=%0d exp=6", bus.alu_ctr); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_zero !== 1'b1) begin fails++; $display("FAIL sub_result got v=%0b r=%0h z=%0b exp 1/0/1", bus.out_valid, bus.out_result, bus.out_zero); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got=%0b exp=1", bus.in_ready); end
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tests++; if (bus.out_valid !== 1'b0 || bus.alu_ctr !== 4'd7) begin fails++; $display("FAIL slt_accept got v=%0b ctr=%0d exp 0/7", bus.out_valid, bus.alu_ctr); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1 || bus.out_zero !== 1'b0) begin fails++; $display("FAIL slt_result got v=%0b r=%0h z=%0b exp 1/1/0", bus.out_valid, bus.out_result, bus.out_zero); end
        step();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 3'd2, 32'h0000_F0F0, 32'h0000_FF00);
        bus.out_ready = 1'b0;
        step();
        drive(1'b1, 3'd0, 32'd1, 32'd1);
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_F000) begin fails++; $display("FAIL and_result got v=%0b r=%0h exp 1/f000", bus.out_valid, bus.out_result); end
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_F000 || bus.in_ready !== 1'b0 || bus.alu_a !== 32'h0000_F0F0)
                begin fails++; $display("FAIL bp_hold[%0d] got v=%0b r=%0h rdy=%0b a=%0h exp 1/f000/0/f0f0", i, bus.out_valid, bus.out_result, bus.in_ready, bus.alu_a); end
        end
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tests++; if (bus.out_valid !== 1'b0 || bus.alu_ctr !== 4'd2 || bus.alu_a !== 32'd1) begin fails++; $display("FAIL bp_next_accept got v=%0b ctr=%0d a=%0h exp 0/2/1", bus.out_valid, bus.alu_ctr, bus.alu_a); end
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2) begin fails++; $display("FAIL bp_next_result got v=%0b r=%0h exp 1/2", bus.out_valid, bus.out_result); end
        step();
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'd6, 32'h1234_5678, 32'h0000_00FF);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tests++; if (bus.alu_ctr !== 4'd15) begin fails++; $display("FAIL ill_alu_ctr got=%0d exp=15", bus.alu_ctr); end
`ifdef ALU_ISSUE_STATS_EN
        tests++; if (stat_illegal !== 32'd1 || stat_ops !== 32'd6) begin fails++; $display("FAIL ill_stats got ops=%0d ill=%0d exp 6/1", stat_ops, stat_illegal); end
`endif
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_zero !== 1'b1 || bus.out_illegal !== 1'b1)
            begin fails++; $display("FAIL ill_result got v=%0b r=%0h z=%0b il=%0b exp 1/0/1/1", bus.out_valid, bus.out_result, bus.out_zero, bus.out_illegal); end
        step();
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 3'd3, 32'd1, 32'd2);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1 || bus.alu_ctr !== 4'd15 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_async got rdy=%0b ctr=%0d v=%0b exp 1/15/0", bus.in_ready, bus.alu_ctr, bus.out_valid); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_idle[%0d] got v=%0b rdy=%0b exp 0/1", i, bus.out_valid, bus.in_ready); end
        end
        drive(1'b1, 3'd5, 32'd0, 32'd0);
        step();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL nor_after_rst got v=%0b r=%0h exp 1/ffffffff", bus.out_valid, bus.out_result); end
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue and result-capture sequencer for the 32-bit integer ALU. It accepts one operation request at a time over a valid/ready handshake and translates a compact 3-bit operation code into the ALU's 4-bit control code. It registers the operands and control into the combinational ALU, captures the ALU result and zero flag, and presents them downstream over a second valid/ready handshake. It sits between instruction decode and writeback, and is the only block that drives the ALU control input.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at a clk edge
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR, 6–7 illegal
- in_a, in_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_ctr  out  4  registered ALU control code
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctr)
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_result  out  WIDTH  captured result
- out_zero  out  1  captured zero flag
- out_illegal  out  1  captured: request used an illegal in_op

## Operation
- FSM states:
  - IDLE: in_ready=1. On accept, latch in_a/in_b into alu_a/alu_b, latch the decoded alu_ctr and the illegal bit, then go to EXEC.
  - EXEC: in_ready=0. At the edge, capture alu_out→out_result, alu_zero→out_zero, and the illegal bit→out_illegal; set out_valid=1; go to DONE.
  - DONE: out_valid=1; outputs are held stable until out_ready. in_ready=out_ready.
    - out_ready && in_valid: accept the new request and go to EXEC. out_valid falls at the same edge.
    - out_ready && !in_valid: clear out_valid and go to IDLE.
    - !out_ready: stay in DONE; operand and result registers do not change.
- Decode of in_op to alu_ctr: ADD→2, SUB→6, AND→0, OR→1, SLT→7, NOR→12, illegal (6, 7)→15.
  - alu_ctr 15 makes the ALU return 0, so out_result=0 and out_zero=1 for illegal ops.
- SLT is unsigned, as the ALU defines it.
- No arithmetic in this block. Widths pass through unchanged; the ADD/SUB carry is discarded by the ALU.
- in_valid while in EXEC is ignored; the requester must hold it until in_ready.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, alu_a=alu_b=0, alu_ctr=15, out_result=0, out_zero=0, out_illegal=0.
- Latency: request accepted at edge N gives out_valid=1 after edge N+1.
- Throughput: with out_ready held high and in_valid continuous, one result every 2 cycles.
- in_ready is combinational from state and out_ready. out_valid and all out_* signals are registered.
- The ALU path is one full cycle: alu_a→alu_out must close within one period.
- rst asserted mid-operation returns to IDLE immediately and discards the in-flight op; the first accept is possible at the first edge after deassertion.

## Configuration
- ALU_ISSUE_STATS_EN defined: adds outputs stat_ops (32) and stat_illegal (32).
  - stat_ops counts accepted requests; stat_illegal counts accepted illegal ops.
  - Both reset to 0, wrap at 2^32, and update at the accept edge.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset then idle: rst pulse → in_ready=1, out_valid=0, alu_ctr=15, out_result=0.
- ADD 5+7, out_ready=1 → alu_ctr=2 one cycle after accept; out_valid after edge N+1 with out_result=12, out_zero=0, out_illegal=0.
- SUB 9−9 then SLT 3<8 back-to-back → out_result=0/out_zero=1, then out_result=1/out_zero=0; results spaced 2 cycles apart.
- Backpressure: AND 0xF0F0&0xFF00 with out_ready=0 for 5 cycles → out_result=0xF000 held stable, in_ready=0. out_ready=1 with in_valid=1 accepts the next op at that edge.
- Illegal op 6 → alu_ctr=15, out_result=0, out_zero=1, out_illegal=1; with ALU_ISSUE_STATS_EN, stat_illegal increments by 1.
- rst asserted during EXEC of OR 1|2 → out_valid stays 0, no result is emitted, and state returns to IDLE.
